seg_scan_arbiter: RTL and testbench
===================================

# seg_scan_arbiter

Time-multiplexed 8-digit 7-segment display scheduler for the matrix calculator. It shares the board's single 8-digit display between three requesters: the error reporter, the compute-result viewer and the menu/status source. It uses fixed-priority arbitration with a minimum hold time, and it drives the digit-scan sequence itself (anode select, segment decode, anti-ghost blanking). It sits between the top-level FSM outputs and the board display pins, and replaces direct per-digit drive.

## Interface

- SCAN_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- HOLD_FRAMES, 64: minimum frames a newly granted requester keeps the display.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  3  display requests. req[2] is error (highest priority), req[1] is result, req[0] is menu (lowest).
- data_err, data_res, data_menu  in  32 each  8 hex nibbles; nibble i = bits [4i+3:4i] is shown on digit i.
- blank_err, blank_res, blank_menu  in  8 each  per-digit blank mask; bit i = 1 blanks digit i.
- grant  out  3  one-hot current owner, or 0 when idle.
- an  out  8  digit anodes, active-low.
- seg  out  7  segments GFEDCBA, active-high, common-cathode encoding, hex 0–F.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation

- **Scan counter**
  - slot_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, slot_cnt wraps to 0 and digit index dig (0..7) increments.
  - When dig goes 7→0, that cycle is the **frame boundary**.
  - Scanning runs continuously, including when idle.
- **Arbitration** is evaluated only at a frame boundary; grant never changes mid-frame. Let cand be the highest-priority asserted req bit.
  - If cand is higher priority than owner: switch to cand and load hold = HOLD_FRAMES.
  - Else if owner's req is still high: keep owner.
  - Else if hold > 0: keep owner, even though its req has dropped.
  - Else: switch to cand and load hold = HOLD_FRAMES. If no req is asserted, switch to idle (grant = 0, hold = 0).
  - Whenever the owner is kept, hold decrements if nonzero.
- **Snapshot**
  - At each frame boundary, after arbitration, the new owner's data and blank inputs are latched into internal 32-bit and 8-bit registers.
  - The whole following frame displays the snapshot, so there is no tearing from input changes mid-frame.
  - When idle, the snapshot is don't-care.
- **Digit drive**, based on registered dig, slot_cnt, grant and snapshot:
  - Drive an = all-ones and seg = 0 if any of the following holds: grant == 0, slot_cnt < BLANK_CYC, or the snapshot blank bit for dig is set.
  - Otherwise drive an = ~(1 << dig) and seg = hex decode of snapshot nibble dig.
- **Hex decode table** (GFEDCBA):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001

## Timing

- **Reset** (asynchronous, takes effect immediately):
  - Outputs: an=8'hFF, seg=0, grant=0, frame_done=0.
  - Internal state: slot_cnt=0, dig=0, hold=0, snapshot=0.
- **First boundary after reset release:** SCAN_DIV·8 − 1 cycles after release (dig wraps from 7).
- **grant and frame_done** are registered and both update in the cycle after the boundary cycle.
- **an and seg** are registered with 1-cycle latency relative to slot_cnt/dig. The first displayed frame after a grant change uses the new snapshot from digit 0.
- **Request latency:** a req asserted one cycle before a boundary is granted at that boundary. A req asserted at or after the boundary waits one full frame.
- **Simultaneous events:** when multiple req bits are asserted, strict priority applies. A higher-priority preemption during a hold is allowed at the next boundary.
- **Zero hold:** HOLD_FRAMES=0 means the owner is released at the first boundary where its req is low.
- **Reset mid-frame:** abandons the frame, with no frame_done pulse.

## Test plan

Bench parameters for all scenarios: SCAN_DIV=4, BLANK_CYC=1, HOLD_FRAMES=2, giving a frame of 32 cycles.

1. **Idle after reset.** Release reset with req=0 and run 100 cycles → an stays 8'hFF, grant=0, and frame_done pulses every 32 cycles.
2. **Menu scan.** req=001, data_menu=32'h7654_3210, blank=0 → after the first boundary grant=001. Each 4-cycle slot shows an all-ones for 1 cycle, then an=~(1<<i) and seg=decode(i) for 3 cycles.
3. **Preemption and hold.** Starting with menu owning, pulse req[2] for 1 cycle just before a boundary → grant=100 for exactly 3 frames (granting frame plus 2 held frames), then grant returns to 001.
4. **No mid-frame change.** Change data_menu from 32'hFFFF_FFFF to 32'h0 at digit 3 → digits 4–7 still show F. The new value appears from the next frame's digit 0.
5. **Blanking.** blank_res=8'b1010_0000 with result owning → digits 5 and 7 give an=8'hFF, seg=0. The other digits decode normally.
6. **Reset mid-frame.** Assert rst_n low at digit 5 while error owns → outputs return to their reset values in the same cycle. After release, the first boundary occurs 31 cycles later.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// Time-multiplexed 8-digit 7-segment scheduler: fixed-priority owner arbitration
// with minimum hold, per-frame snapshot, digit scan with anti-ghost blanking.
module seg_scan_arbiter #(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [31:0] data_err,
    input  logic [31:0] data_res,
    input  logic [31:0] data_menu,
    input  logic [7:0]  blank_err,
    input  logic [7:0]  blank_res,
    input  logic [7:0]  blank_menu,
    output logic [2:0]  grant,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

    // One-hot owner encoding doubles as the grant vector; larger value = higher priority.
    typedef enum logic [2:0] {
        OWN_IDLE = 3'b000,
        OWN_MENU = 3'b001,
        OWN_RES  = 3'b010,
        OWN_ERR  = 3'b100
    } owner_t;

    owner_t              state, state_nxt, cand_c;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [2:0]          dig;
    logic [HOLD_W-1:0]   hold, hold_nxt;
    logic [31:0]         snap_data, snap_data_nxt;
    logic [7:0]          snap_blank, snap_blank_nxt;
    logic                boundary_c;
    logic [7:0]          an_c;
    logic [6:0]          seg_c;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;
            4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    assign boundary_c = (slot_cnt == SLOT_LAST) && (dig == 3'd7);
    assign grant      = 3'(state);

    // Free-running slot/digit scan counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig      <= 3'd0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            dig      <= dig + 3'd1;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Highest-priority pending requester.
    always_comb begin
        cand_c = OWN_IDLE;
        if (req[2])      cand_c = OWN_ERR;
        else if (req[1]) cand_c = OWN_RES;
        else if (req[0]) cand_c = OWN_MENU;
    end

    // Owner state, hold counter and snapshot; all change only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OWN_IDLE;
            hold       <= '0;
            snap_data  <= '0;
            snap_blank <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            snap_data  <= snap_data_nxt;
            snap_blank <= snap_blank_nxt;
            frame_done <= boundary_c;
        end
    end

    // Arbitration and snapshot selection for the next frame.
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold;
        snap_data_nxt  = snap_data;
        snap_blank_nxt = snap_blank;
        if (boundary_c) begin
            if (3'(cand_c) > 3'(state)) begin
                state_nxt = cand_c;
                hold_nxt  = HOLD_LOAD;
            end else if (((req & 3'(state)) != 3'b000) || (hold != '0)) begin
                if (hold != '0) hold_nxt = hold - HOLD_W'(1);
            end else begin
                state_nxt = cand_c;
                hold_nxt  = (cand_c == OWN_IDLE) ? '0 : HOLD_LOAD;
            end
            case (state_nxt)
                OWN_ERR: begin
                    snap_data_nxt  = data_err;
                    snap_blank_nxt = blank_err;
                end
                OWN_RES: begin
                    snap_data_nxt  = data_res;
                    snap_blank_nxt = blank_res;
                end
                OWN_MENU: begin
                    snap_data_nxt  = data_menu;
                    snap_blank_nxt = blank_menu;
                end
                default: begin
                    snap_data_nxt  = '0;
                    snap_blank_nxt = '0;
                end
            endcase
        end
    end

    // Digit drive: blank while idle, during the slot's leading gap, or when masked.
    always_comb begin
        an_c  = 8'hFF;
        seg_c = 7'd0;
        if ((state != OWN_IDLE) && (slot_cnt >= SLOT_BLANK) && !snap_blank[dig]) begin
            an_c  = ~(8'd1 << dig);
            seg_c = hex7(snap_data[{dig, 2'b00} +: 4]);
        end
    end

    // Registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 8'hFF;
            seg <= 7'd0;
        end else begin
            an  <= an_c;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with SCAN_DIV=4, BLANK_CYC=1, HOLD_FRAMES=2.
module tb_seg_scan_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] data_err, data_res, data_menu;
    logic [7:0]  blank_err, blank_res, blank_menu;
    logic [2:0]  grant;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg_scan_arbiter #(
        .SCAN_DIV    (4),
        .BLANK_CYC   (1),
        .HOLD_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_err   (data_err),
        .data_res   (data_res),
        .data_menu  (data_menu),
        .blank_err  (blank_err),
        .blank_res  (blank_res),
        .blank_menu (blank_menu),
        .grant      (grant),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'b0111111;  4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;  4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;  4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;  4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;  4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;  default: hex7 = 7'b1110001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; samples on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Step one cycle, then check pins. g_disp is the owner during the previous
    // counter position (what an/seg now reflect); g_out is the grant expected now.
    task automatic cyc_chk(input logic [2:0] g_disp, input logic [2:0] g_out,
                           input logic [31:0] d, input logic [7:0] b);
        int t, dg, sl;
        logic [7:0] ea;
        logic [6:0] es;
        step();
        t  = (cyc - 1) % 32;
        dg = t / 4;
        sl = t % 4;
        if (g_disp == 3'b000 || sl < 1 || b[dg]) begin
            ea = 8'hFF;
            es = 7'd0;
        end else begin
            ea = ~(8'd1 << dg);
            es = hex7(d[dg*4 +: 4]);
        end
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
        chk("frame_done", 32'(frame_done), 32'((cyc % 32) == 0));
        chk("grant", 32'(grant), 32'(g_out));
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 3'b000;
        data_err   = 32'h0;
        data_res   = 32'h0;
        data_menu  = 32'h0;
        blank_err  = 8'h00;
        blank_res  = 8'h00;
        blank_menu = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'h0000_00FF);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);

        // Idle after reset: blank display, frame_done every 32 cycles
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 1; c <= 100; c++) cyc_chk(3'b000, 3'b000, 32'h0, 8'h00);

        // Menu request granted at the next boundary (edge 128)
        data_menu = 32'h7654_3210;
        data_err  = 32'hEEEE_EEEE;
        data_res  = 32'h89AB_CDEF;
        blank_res = 8'b1010_0000;
        req       = 3'b001;
        for (int c = 101; c <= 128; c++)
            cyc_chk(3'b000, (c == 128) ? 3'b001 : 3'b000, 32'h0, 8'h00);
        for (int c = 129; c <= 191; c++) cyc_chk(3'b001, 3'b001, 32'h7654_3210, 8'h00);

        // One-cycle error pulse during the boundary cycle preempts; held 3 frames
        req = 3'b101;
        cyc_chk(3'b001, 3'b100, 32'h7654_3210, 8'h00);
        req = 3'b001;
        for (int c = 193; c <= 288; c++)
            cyc_chk(3'b100, (c < 288) ? 3'b100 : 3'b001, 32'hEEEE_EEEE, 8'h00);

        // Mid-frame input changes do not tear the displayed frame
        for (int c = 289; c <= 320; c++) begin
            cyc_chk(3'b001, 3'b001, 32'h7654_3210, 8'h00);
            if (c == 300) data_menu = 32'hFFFF_FFFF;
        end
        for (int c = 321; c <= 352; c++) begin
            cyc_chk(3'b001, 3'b001, 32'hFFFF_FFFF, 8'h00);
            if (c == 333) data_menu = 32'h0;
        end

        // Result request raised after the boundary waits a full frame
        req = 3'b010;
        for (int c = 353; c <= 384; c++)
            cyc_chk(3'b001, (c < 384) ? 3'b001 : 3'b010, 32'h0, 8'h00);

        // Result owns with digits 5 and 7 blanked
        for (int c = 385; c <= 416; c++) cyc_chk(3'b010, 3'b010, 32'h89AB_CDEF, 8'hA0);
        req      = 3'b100;
        data_err = 32'h0123_4567;
        for (int c = 417; c <= 448; c++)
            cyc_chk(3'b010, (c < 448) ? 3'b100 & {3{c >= 448}} | ((c < 448) ? 3'b010 : 3'b000) : 3'b100,
                    32'h89AB_CDEF, 8'hA0);

        // Error owns; reset asserted at digit 5
        for (int c = 449; c <= 471; c++) cyc_chk(3'b100, 3'b100, 32'h0123_4567, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midrst_an", 32'(an), 32'h0000_00FF);
        chk("midrst_seg", 32'(seg), 32'h0);
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_frame_done", 32'(frame_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 1; c <= 32; c++)
            cyc_chk(3'b000, (c < 32) ? 3'b000 : 3'b100, 32'h0, 8'h00);
        for (int c = 33; c <= 64; c++) cyc_chk(3'b100, 3'b100, 32'h0123_4567, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
